// File: rtl/dac_sample_sequencer_if.sv
// Handshake bundle between the sample sequencer and the SPI DAC serializer.
// The sequencer drives the sample and start pulse; the DAC returns its chip select as a busy flag.
interface dac_sample_sequencer_if;
    logic        dac_cs;
    logic [11:0] dac_datain;
    logic        dac_start;

    modport master (
        input  dac_cs,
        output dac_datain,
        output dac_start
    );

    modport slave (
        output dac_cs,
        input  dac_datain,
        input  dac_start
    );
endinterface

// File: rtl/dac_sample_sequencer.sv
// Waveform sample generator feeding the SPI DAC: phase accumulator, sample-rate divider,
// transfer FSM with overrun and stuck-DAC detection.
module dac_sample_sequencer #(
    parameter int unsigned DIV      = 64,
    parameter int unsigned BUSY_TMO = 8
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          en,
    input  logic [1:0]                    wave_sel,
    input  logic [11:0]                   step,
    input  logic                          clr_flags,
    dac_sample_sequencer_if.master        dac,
    output logic                          busy,
    output logic                          overrun,
    output logic                          dac_err,
    output logic [15:0]                   sample_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0] TMO_LIM  = 16'(BUSY_TMO);
    localparam logic [1:0]  WAVE_DC  = 2'd3;

    state_t      state_r;
    state_t      state_nx_s;
    logic [15:0] div_r;
    logic [15:0] tmo_r;
    logic [15:0] tmo_nx_s;
    logic [11:0] phase_r;
    logic [11:0] datain_r;
    logic        start_r;
    logic        busy_r;
    logic        overrun_r;
    logic        dac_err_r;
    logic [15:0] sample_cnt_r;
    logic        tick_s;
    logic        load_s;
    logic        done_s;
    logic        err_set_s;
    logic        ovr_set_s;

    function automatic logic [11:0] wave_sample(input logic [1:0]  sel,
                                                input logic [11:0] ph,
                                                input logic [11:0] lvl);
        logic [11:0] s;
        case (sel)
            2'd0:    s = ph;
            2'd1:    s = ph[11] ? {~ph[10:0], 1'b0} : {ph[10:0], 1'b0};
            2'd2:    s = ph[11] ? 12'hFFF : 12'h000;
            2'd3:    s = lvl;
            default: s = 12'h000;
        endcase
        return s;
    endfunction

    // Sample-rate divider; parked at zero while generation is disabled
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            div_r <= 16'd0;
        end else if (!en) begin
            div_r <= 16'd0;
        end else if (div_r == DIV_LAST) begin
            div_r <= 16'd0;
        end else begin
            div_r <= div_r + 16'd1;
        end
    end

    // Tick decode and transfer FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        tmo_nx_s   = tmo_r;
        load_s     = 1'b0;
        done_s     = 1'b0;
        err_set_s  = 1'b0;
        tick_s     = en && (div_r == DIV_LAST);
        ovr_set_s  = tick_s && (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                tmo_nx_s   = 16'd0;
                state_nx_s = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!dac.dac_cs) begin
                    state_nx_s = ST_WAIT_HIGH;
                end else begin
                    tmo_nx_s = tmo_r + 16'd1;
                    // A DAC that never drops cs is abandoned without counting the sample
                    if (tmo_nx_s == TMO_LIM) begin
                        err_set_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_WAIT_LOW;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (dac.dac_cs) begin
                    done_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, timeout counter and registered handshake outputs
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            tmo_r    <= 16'd0;
            start_r  <= 1'b0;
            busy_r   <= 1'b0;
            datain_r <= 12'h000;
            phase_r  <= 12'h000;
        end else begin
            state_r <= state_nx_s;
            tmo_r   <= tmo_nx_s;
            start_r <= (state_nx_s == ST_START);
            busy_r  <= (state_nx_s != ST_IDLE);
            if (load_s) begin
                datain_r <= wave_sample(wave_sel, phase_r, step);
            end
            if (load_s && (wave_sel != WAVE_DC)) begin
                phase_r <= phase_r + step;
            end
        end
    end

    // Sticky error flags (a new event beats a simultaneous clear) and transfer count
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            overrun_r    <= 1'b0;
            dac_err_r    <= 1'b0;
            sample_cnt_r <= 16'd0;
        end else begin
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_flags) begin
                overrun_r <= 1'b0;
            end
            if (err_set_s) begin
                dac_err_r <= 1'b1;
            end else if (clr_flags) begin
                dac_err_r <= 1'b0;
            end
            if (done_s) begin
                sample_cnt_r <= sample_cnt_r + 16'd1;
            end
        end
    end

    assign dac.dac_datain = datain_r;
    assign dac.dac_start  = start_r;
    assign busy           = busy_r;
    assign overrun        = overrun_r;
    assign dac_err        = dac_err_r;
    assign sample_cnt     = sample_cnt_r;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Directed bench for dac_sample_sequencer: table of per-frame samples plus hand-written
// sequences for overrun, stuck DAC, mid-transfer disable and asynchronous reset.
module tb_dac_sample_sequencer;

    localparam int DIV      = 40;
    localparam int BUSY_TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  wave_sel;
    logic [11:0] step;
    logic        clr_flags;
    logic        busy;
    logic        overrun;
    logic        dac_err;
    logic [15:0] sample_cnt;

    dac_sample_sequencer_if dac ();

    dac_sample_sequencer #(.DIV(DIV), .BUSY_TMO(BUSY_TMO)) dut (
        .clk_in     (clk),
        .rst        (rst),
        .en         (en),
        .wave_sel   (wave_sel),
        .step       (step),
        .clr_flags  (clr_flags),
        .dac        (dac),
        .busy       (busy),
        .overrun    (overrun),
        .dac_err    (dac_err),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    // DAC model: cs drops two edges after the start pulse and stays low frame_len cycles
    int frame_len = 17;
    bit cs_stuck  = 1'b0;
    int k;
    always @(posedge clk or negedge rst) begin
        if (!rst)                               k <= 0;
        else if (dac.dac_start)                 k <= 1;
        else if (k != 0 && k < 2 + frame_len)   k <= k + 1;
        else                                    k <= 0;
    end
    assign dac.dac_cs = cs_stuck ? 1'b1 : !(k >= 2 && k < 2 + frame_len);

    int cyc = 0;
    int n_starts = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dac.dac_start === 1'b1) n_starts <= n_starts + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_start(input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (dac.dac_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: no dac_start within 300 cycles", name);
        end
    endtask

    task automatic wait_idle(input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: busy still high after 300 cycles", name);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        en        = 1'b0;
        clr_flags = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit          do_rst;
        bit          chk_gap;
        logic [1:0]  wave;
        logic [11:0] step;
        logic [11:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[32];
    int   nv = 0;

    task automatic add(input bit r, input bit g, input logic [1:0] w, input logic [11:0] s,
                       input logic [11:0] d, input logic [15:0] c);
        vecs[nv].do_rst   = r;
        vecs[nv].chk_gap  = g;
        vecs[nv].wave     = w;
        vecs[nv].step     = s;
        vecs[nv].exp_data = d;
        vecs[nv].exp_cnt  = c;
        nv++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          last_start;
        int          c;
        logic [11:0] held;
        bit          stable;
        int          starts_snap;

        rst = 1'b0; en = 1'b0; clr_flags = 1'b0; wave_sel = 2'd0; step = 12'h000;

        // Sawtooth 0x100: one full lap of the accumulator and back to 0x000
        for (int i = 0; i < 17; i++) begin
            logic [11:0] v;
            v = 12'(i * 256);
            add(i == 0, i != 0, 2'd0, 12'h100, v, 16'(i + 1));
        end
        // Triangle 0x400: rising half then falling half
        add(1'b1, 1'b1, 2'd1, 12'h400, 12'h000, 16'd1);
        add(1'b0, 1'b1, 2'd1, 12'h400, 12'h800, 16'd2);
        add(1'b0, 1'b1, 2'd1, 12'h400, 12'hFFE, 16'd3);
        add(1'b0, 1'b1, 2'd1, 12'h400, 12'h7FE, 16'd4);
        add(1'b0, 1'b1, 2'd1, 12'h400, 12'h000, 16'd5);
        // Square 0x400
        add(1'b1, 1'b1, 2'd2, 12'h400, 12'h000, 16'd1);
        add(1'b0, 1'b1, 2'd2, 12'h400, 12'h000, 16'd2);
        add(1'b0, 1'b1, 2'd2, 12'h400, 12'hFFF, 16'd3);
        add(1'b0, 1'b1, 2'd2, 12'h400, 12'hFFF, 16'd4);
        // DC 0xABC, then sawtooth exposes the untouched phase
        add(1'b1, 1'b1, 2'd3, 12'hABC, 12'hABC, 16'd1);
        add(1'b0, 1'b1, 2'd3, 12'hABC, 12'hABC, 16'd2);
        add(1'b0, 1'b1, 2'd3, 12'hABC, 12'hABC, 16'd3);
        add(1'b0, 1'b1, 2'd0, 12'h010, 12'h000, 16'd4);
        add(1'b0, 1'b1, 2'd0, 12'h010, 12'h010, 16'd5);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_datain",  32'(dac.dac_datain), 32'h000);
        check("rst_start",   32'(dac.dac_start),  32'h0);
        check("rst_busy",    32'(busy),           32'h0);
        check("rst_overrun", 32'(overrun),        32'h0);
        check("rst_err",     32'(dac_err),        32'h0);
        check("rst_cnt",     32'(sample_cnt),     32'h0);
        rst = 1'b1;

        last_start = 0;
        for (int i = 0; i < nv; i++) begin
            if (vecs[i].do_rst) do_reset();
            wave_sel = vecs[i].wave;
            step     = vecs[i].step;
            en       = 1'b1;
            wait_start($sformatf("vec%0d_start", i), ok);
            if (ok) begin
                check($sformatf("vec%0d_datain", i), 32'(dac.dac_datain), 32'(vecs[i].exp_data));
                if (vecs[i].chk_gap && !vecs[i].do_rst)
                    check($sformatf("vec%0d_start_gap", i), 32'(cyc - last_start), 32'(DIV));
                last_start = cyc;
                @(negedge clk);
                check($sformatf("vec%0d_start_width", i), 32'(dac.dac_start), 32'h0);
                wait_idle($sformatf("vec%0d_idle", i), ok);
                if (ok) check($sformatf("vec%0d_cnt", i), 32'(sample_cnt), 32'(vecs[i].exp_cnt));
            end
        end
        check("normal_overrun", 32'(overrun), 32'h0);
        check("normal_err",     32'(dac_err), 32'h0);

        // Mid-transfer input changes and disable: sample held, frame completes, no new ticks
        wait_start("hold_start", ok);
        check("hold_datain", 32'(dac.dac_datain), 32'h020);
        held     = dac.dac_datain;
        wave_sel = 2'd2;
        step     = 12'hFFF;
        en       = 1'b0;
        stable   = 1'b1;
        for (c = 0; c < 300 && busy === 1'b1; c++) begin
            @(negedge clk);
            if (dac.dac_datain !== held) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'h1);
        check("hold_cnt", 32'(sample_cnt), 32'd6);
        starts_snap = n_starts;
        repeat (100) @(negedge clk);
        check("disabled_starts", 32'(n_starts - starts_snap), 32'd0);
        check("disabled_busy", 32'(busy), 32'h0);

        // Overrun: 50-cycle frames against a 40-cycle tick
        do_reset();
        frame_len = 50;
        wave_sel  = 2'd0;
        step      = 12'h100;
        en        = 1'b1;
        wait_start("ovr_start0", ok);
        check("ovr_datain0", 32'(dac.dac_datain), 32'h000);
        ok = 1'b0;
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (overrun === 1'b1) begin ok = 1'b1; break; end
        end
        check("ovr_set", 32'(ok), 32'h1);
        check("ovr_busy_at_set", 32'(busy), 32'h1);
        wait_idle("ovr_idle0", ok);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);
        wait_start("ovr_start1", ok);
        check("ovr_dropped_not_sent", 32'(dac.dac_datain), 32'h100);
        // clr held high across the next collision: the set must still show for a cycle
        clr_flags = 1'b1;
        ok = 1'b0;
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (overrun === 1'b1) begin ok = 1'b1; break; end
        end
        check("ovr_set_beats_clr", 32'(ok), 32'h1);
        @(negedge clk);
        check("ovr_clr_after_set", 32'(overrun), 32'h0);
        clr_flags = 1'b0;
        en        = 1'b0;
        wait_idle("ovr_idle1", ok);
        frame_len = 17;

        // Stuck DAC: cs never falls
        do_reset();
        cs_stuck = 1'b1;
        wave_sel = 2'd0;
        step     = 12'h100;
        en       = 1'b1;
        wait_start("tmo_start", ok);
        ok = 1'b0;
        for (c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (dac_err === 1'b1) begin ok = 1'b1; break; end
        end
        check("tmo_err_seen", 32'(ok), 32'h1);
        // err shows after BUSY_TMO full cycles in WAIT_LOW, i.e. on the 9th sample after start
        check("tmo_err_latency", 32'(c), 32'(BUSY_TMO + 1));
        check("tmo_busy", 32'(busy), 32'h0);
        check("tmo_cnt", 32'(sample_cnt), 32'h0);
        en        = 1'b0;
        cs_stuck  = 1'b0;
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("tmo_err_cleared", 32'(dac_err), 32'h0);

        // Asynchronous reset during WAIT_HIGH of the second frame
        do_reset();
        wave_sel = 2'd0;
        step     = 12'h300;
        en       = 1'b1;
        wait_start("ar_start0", ok);
        wait_idle("ar_idle0", ok);
        wait_start("ar_start1", ok);
        check("ar_datain1", 32'(dac.dac_datain), 32'h300);
        for (c = 0; c < 20 && dac.dac_cs !== 1'b0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("ar_in_wait_high", 32'({busy, dac.dac_cs}), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        check("ar_busy",   32'(busy),           32'h0);
        check("ar_start",  32'(dac.dac_start),  32'h0);
        check("ar_datain", 32'(dac.dac_datain), 32'h000);
        check("ar_cnt",    32'(sample_cnt),     32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_start("ar_start2", ok);
        check("ar_first_sample", 32'(dac.dac_datain), 32'h000);
        wait_idle("ar_idle2", ok);
        check("ar_cnt_after", 32'(sample_cnt), 32'd1);
        en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
